// File: rtl/led_blink_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : led_blink_scheduler
// Description : Shares one LED between four requesters. A round-robin
//               arbiter picks a requester, latches its 4-bit blink count,
//               and plays that many on/off blinks of PERIOD cycles each,
//               followed by a dark gap of GAP_PHASES*PERIOD cycles and a
//               one-cycle done pulse.
// Ports       : clk    - sole clock, rising edge
//               reset  - asynchronous, active-low reset
//               req    - [3:0] request level per requester
//               blinks - [15:0] blink count of requester i in [4i+3:4i]
//               grant  - [3:0] one-hot owner of the LED, zero when idle
//               done   - [3:0] one-cycle end-of-sequence pulse to the owner
//               busy   - high whenever the scheduler is not idle
//               led    - registered LED drive
// Revision    : 1.0 - initial release
// ============================================================================
module led_blink_scheduler #(
    parameter int PERIOD     = 100,
    parameter int GAP_PHASES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] blinks,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic        led
);

    // The gap is the longest phase, so its length sizes the timer.
    localparam int GAP_CYCLES = GAP_PHASES * PERIOD;
    localparam int TW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TW-1:0] PHASE_LAST = TW'(PERIOD - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ON   = 3'd1;
    localparam logic [2:0] S_OFF  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    r_state;
    logic [1:0]    r_ptr;
    logic [1:0]    r_owner;
    logic [3:0]    r_grant;
    logic [3:0]    r_remaining;
    logic [TW-1:0] r_timer;
    logic          r_led;

    logic          w_win_valid;
    logic [1:0]    w_win_idx;
    logic [3:0]    w_win_count;

    // Round-robin search from r_ptr upward. The loop runs from the farthest
    // candidate down so that the nearest requesting one is written last.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            logic [1:0] cand;
            cand = r_ptr + 2'(k);
            if (req[cand]) begin
                w_win_valid = 1'b1;
                w_win_idx   = cand;
            end
        end
    end

    assign w_win_count = blinks[{w_win_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_owner     <= 2'd0;
            r_grant     <= 4'd0;
            r_remaining <= 4'd0;
            r_timer     <= '0;
            r_led       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_owner     <= w_win_idx;
                        r_grant     <= 4'b0001 << w_win_idx;
                        r_remaining <= w_win_count;
                        r_timer     <= '0;
                        if (w_win_count != 4'd0) begin
                            r_state <= S_ON;
                            r_led   <= 1'b1;
                        end else begin
                            // Zero blinks: skip straight to the done pulse.
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ON: begin
                    if (r_timer == PHASE_LAST) begin
                        r_state     <= S_OFF;
                        r_led       <= 1'b0;
                        r_timer     <= '0;
                        r_remaining <= r_remaining - 4'd1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_OFF: begin
                    if (r_timer == PHASE_LAST) begin
                        r_timer <= '0;
                        if (r_remaining != 4'd0) begin
                            r_state <= S_ON;
                            r_led   <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_timer == GAP_LAST) begin
                        r_state <= S_DONE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    // The requester after the one just served gets first look.
                    r_state <= S_IDLE;
                    r_grant <= 4'd0;
                    r_ptr   <= r_owner + 2'd1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 4'd0;
                    r_led   <= 1'b0;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign led   = r_led;
    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE) ? r_grant : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_blink_scheduler
// Description : Self-checking bench for led_blink_scheduler (PERIOD=4,
//               GAP_PHASES=2). A sequence-level reference model predicts
//               grant/done/busy/led every cycle; table vectors and directed
//               sequences check lengths, orders and blink counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_scheduler;

    localparam int P = 4;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [15:0] blinks = 16'd0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        led;

    int checks = 0;
    int errors = 0;

    led_blink_scheduler #(.PERIOD(P), .GAP_PHASES(G)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .blinks (blinks),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .led    (led)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: one sequence = owner, count, offset
    bit m_active = 1'b0;
    int m_owner  = 0;
    int m_n      = 0;
    int m_k      = 0;
    int m_ptr    = 0;

    function automatic int seq_len(input int n);
        return (n == 0) ? 1 : (2 * n * P + G * P + 1);
    endfunction

    task automatic model_step(input logic [3:0] r, input logic [15:0] b);
        if (m_active) begin
            if (m_k == seq_len(m_n) - 1) begin
                m_active = 1'b0;
                m_ptr    = (m_owner + 1) % 4;
            end else begin
                m_k++;
            end
        end else if (r != 4'd0) begin
            for (int j = 0; j < 4; j++) begin
                int idx;
                idx = (m_ptr + j) % 4;
                if (r[idx] && !m_active) begin
                    m_active = 1'b1;
                    m_owner  = idx;
                    m_n      = int'(b[4*idx +: 4]);
                    m_k      = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] eg, ed;
        logic       eb, el;
        eg = m_active ? (4'b0001 << m_owner) : 4'd0;
        eb = m_active;
        ed = (m_active && m_k == seq_len(m_n) - 1) ? eg : 4'd0;
        el = m_active && m_n > 0 && m_k < 2 * m_n * P && (m_k % (2 * P)) < P;
        checks++;
        if (grant !== eg || done !== ed || busy !== eb || led !== el) begin
            errors++;
            $display("FAIL model t=%0t grant/done/busy/led got %b/%b/%b/%b want %b/%b/%b/%b",
                     $time, grant, done, busy, led, eg, ed, eb, el);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, check at negedge.
    task automatic cycle(input logic [3:0] r, input logic [15:0] b);
        req    = r;
        blinks = b;
        @(posedge clk);
        model_step(r, b);
        @(negedge clk);
        check_model();
    endtask

    // Called at a negedge; asserts reset away from any rising edge.
    task automatic do_reset();
        req   = 4'd0;
        reset = 1'b0;
        #1;
        check_val("reset_outputs_zero", int'({grant, done, busy, led}), 0);
        m_active = 1'b0;
        m_ptr    = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_grant(input logic [3:0] r, input logic [15:0] b,
                              output logic [3:0] first);
        int n = 0;
        while (grant == 4'd0 && n < 10) begin
            cycle(r, b);
            n++;
        end
        if (grant == 4'd0) begin
            errors++;
            checks++;
            $display("FAIL wait_grant timeout got %b want nonzero", grant);
        end
        first = grant;
    endtask

    // From the first granted cycle, run with req low until grant clears.
    task automatic measure(input logic [15:0] b, input logic [15:0] b_late,
                           input int switch_at,
                           output int len, output int rises, output int dones);
        logic prev_led = 1'b0;
        int   guard = 0;
        len = 0; rises = 0; dones = 0;
        while (grant != 4'd0 && guard < 400) begin
            len++;
            if (led && !prev_led) rises++;
            if (done != 4'd0) dones++;
            prev_led = led;
            cycle(4'd0, (len >= switch_at) ? b_late : b);
            guard++;
        end
        if (guard >= 400) begin
            errors++;
            checks++;
            $display("FAIL measure timeout got grant %b want 0", grant);
        end
    endtask

    // Held request: record successive grants, their lengths and idle gaps.
    task automatic stream(input logic [3:0] r, input logic [15:0] b,
                          input int ngr, input logic [19:0] order, input int exp_len);
        logic [3:0] prev = 4'd0;
        int seen = 0, glen = 0, idle = 0, guard = 0;
        while (seen < ngr && guard < 500) begin
            cycle(r, b);
            guard++;
            if (grant != 4'd0) begin
                if (prev == 4'd0) begin
                    check_val("stream_order", int'(grant), int'(order[4*seen +: 4]));
                    if (seen > 0) check_val("stream_idle_gap", idle, 1);
                    seen++;
                    glen = 1;
                end else begin
                    glen++;
                end
            end else begin
                if (prev != 4'd0) begin
                    check_val("stream_grant_len", glen, exp_len);
                    idle = 0;
                end
                idle++;
            end
            prev = grant;
        end
        if (seen < ngr) check_val("stream_timeout", seen, ngr);
    endtask

    typedef struct {
        logic [3:0]  r;
        logic [15:0] b;
        logic [3:0]  exp_grant;
        int          exp_len;
        int          exp_rises;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [3:0] first;
        int len, rises, dones;

        vecs[0] = '{4'b0001, 16'h0003, 4'b0001, 33,  3};
        vecs[1] = '{4'b0100, 16'h0000, 4'b0100, 1,   0};
        vecs[2] = '{4'b0010, 16'h00F0, 4'b0010, 129, 15};
        vecs[3] = '{4'b1000, 16'h1000, 4'b1000, 17,  1};
        vecs[4] = '{4'b1010, 16'h2020, 4'b0010, 25,  2};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            do_reset();
            wait_grant(vecs[i].r, vecs[i].b, first);
            check_val("vec_first_grant", int'(first), int'(vecs[i].exp_grant));
            measure(vecs[i].b, vecs[i].b, 1000, len, rises, dones);
            check_val("vec_grant_len", len, vecs[i].exp_len);
            check_val("vec_led_rises", rises, vecs[i].exp_rises);
            check_val("vec_done_pulses", dones, 1);
        end

        // All four requesting with count 1: strict rotation, one idle cycle.
        do_reset();
        stream(4'b1111, 16'h1111, 5, {4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001}, 17);

        // Changes to req/blinks after the grant must not alter the sequence.
        do_reset();
        wait_grant(4'b0010, 16'h0050, first);
        measure(16'h0050, 16'h0010, 3, len, rises, dones);
        check_val("latch_led_rises", rises, 5);
        check_val("latch_done_pulses", dones, 1);

        // Reset in the second ON phase abandons the sequence silently.
        do_reset();
        wait_grant(4'b0001, 16'h0003, first);
        for (int i = 0; i < 9; i++) cycle(4'd0, 16'h0003);
        check_val("second_on_led", int'(led), 1);
        do_reset();
        wait_grant(4'b1001, 16'h1001, first);
        check_val("post_reset_grant", int'(first), 1);

        // Single requester held: repeated service with one idle cycle.
        do_reset();
        stream(4'b0001, 16'h0002, 3, {4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001}, 25);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [3:0]  rr;
            logic [15:0] bb;
            rr = 4'($urandom_range(0, 15));
            bb = 16'($urandom) & 16'h3333;
            cycle(rr, bb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
